// File: rtl/huff_ctrl.sv
// huff_ctrl: sequencing controller for a JPEG-style Huffman AC decoder.
// Walks the code length on Table 1 until the datapath comparator reports a
// match, reads {run,size} from Table 2, then counts the coefficient bits and
// emits one strobe per coefficient with its zig-zag position.
//
// Ports
//   phi1            clock, rising edge
//   reset_b         asynchronous active-low reset
//   start_s1        start a 64-coefficient block (ignored while busy)
//   bit_valid_s1    datapath shifted a bitstream bit this cycle
//   match_s1        datapath comparator: current bits <= maxcode
//   table2_data_v1  {run[7:4], size[3:0]}, valid in LOOKUP
//   table1_addr_s1  current code length 1..9
//   reset_sr_s2     one-cycle clear of the datapath shift register
//   coeff_en_b_s2   low while coefficient bits are shifted
//   coeff_valid_s2  coefficient strobe, with run_s2/size_s2/index_s2
//   busy_s1         decoding a block
//   block_done_s1   block finished (level)
//   err_s1          bitstream error (level)
//
// Build option: HUFF_CTRL_ERR_DETECT_EN
//   defined   - over-long code, illegal size-0 code and index overflow go to ERR
//   undefined - length 9 forces a lookup, illegal size-0 code acts as EOB,
//               index saturates at 64 and ends the block; err_s1 stays 0
//
// state  | meaning
// IDLE   | waiting for start after reset
// CODE   | shifting Huffman code bits, growing code_len
// LOOKUP | Table 2 data valid, decode run/size
// COEFF  | shifting size coefficient bits (down-counter)
// DONE   | block complete, waiting for start
// ERR    | bitstream error, waiting for start

module huff_ctrl (
   input  logic       phi1,
   input  logic       reset_b,
   input  logic       start_s1,
   input  logic       bit_valid_s1,
   input  logic       match_s1,
   input  logic [7:0] table2_data_v1,
   output logic [3:0] table1_addr_s1,
   output logic       reset_sr_s2,
   output logic       coeff_en_b_s2,
   output logic       coeff_valid_s2,
   output logic [3:0] run_s2,
   output logic [3:0] size_s2,
   output logic [5:0] index_s2,
   output logic       busy_s1,
   output logic       block_done_s1,
   output logic       err_s1
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CODE   = 3'd1,
      ST_LOOKUP = 3'd2,
      ST_COEFF  = 3'd3,
      ST_DONE   = 3'd4,
      ST_ERR    = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] code_len_q, code_len_d;
   logic [6:0] index_q, index_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [3:0] run_q, run_d;
   logic [3:0] size_q, size_d;

   logic [6:0] pos;
   logic [6:0] nxt_idx;
   logic [6:0] zrl_idx;
   logic [3:0] tbl_run;
   logic [3:0] tbl_size;

   // 7-bit index math so that 64 and overflow are representable
   assign pos      = index_q + {3'b000, run_q};
   assign nxt_idx  = pos + 7'd1;
   assign zrl_idx  = index_q + 7'd16;
   assign tbl_run  = table2_data_v1[7:4];
   assign tbl_size = table2_data_v1[3:0];

   always_ff @(posedge phi1 or negedge reset_b) begin
      if (!reset_b) begin
         state_q    <= ST_IDLE;
         code_len_q <= 4'd1;
         index_q    <= 7'd0;
         bit_cnt_q  <= 4'd0;
         run_q      <= 4'd0;
         size_q     <= 4'd0;
      end else begin
         state_q    <= state_d;
         code_len_q <= code_len_d;
         index_q    <= index_d;
         bit_cnt_q  <= bit_cnt_d;
         run_q      <= run_d;
         size_q     <= size_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      code_len_d     = code_len_q;
      index_d        = index_q;
      bit_cnt_d      = bit_cnt_q;
      run_d          = run_q;
      size_d         = size_q;
      reset_sr_s2    = 1'b0;
      coeff_valid_s2 = 1'b0;
      coeff_en_b_s2  = 1'b1;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start_s1) begin
               state_d    = ST_CODE;
               code_len_d = 4'd1;
               index_d    = 7'd0;
               bit_cnt_d  = 4'd0;
               run_d      = 4'd0;
               size_d     = 4'd0;
            end
         end

         ST_CODE: begin
            if (bit_valid_s1) begin
               // a single bit is never a complete code, so match is ignored at length 1
               if ((code_len_q >= 4'd2) && match_s1) begin
                  state_d     = ST_LOOKUP;
                  reset_sr_s2 = 1'b1;
               end else if (code_len_q == 4'd9) begin
`ifdef HUFF_CTRL_ERR_DETECT_EN
                  state_d     = ST_ERR;
`else
                  state_d     = ST_LOOKUP;
                  reset_sr_s2 = 1'b1;
`endif
               end else begin
                  code_len_d = code_len_q + 4'd1;
               end
            end
         end

         ST_LOOKUP: begin
            run_d      = tbl_run;
            size_d     = tbl_size;
            code_len_d = 4'd1;
            if (tbl_size != 4'd0) begin
               state_d   = ST_COEFF;
               bit_cnt_d = tbl_size;
            end else if (tbl_run == 4'd0) begin
               state_d = ST_DONE;
            end else if (tbl_run == 4'd15) begin
               if (zrl_idx < 7'd64) begin
                  index_d = zrl_idx;
                  state_d = ST_CODE;
               end else if (zrl_idx == 7'd64) begin
                  index_d = zrl_idx;
                  state_d = ST_DONE;
               end else begin
`ifdef HUFF_CTRL_ERR_DETECT_EN
                  state_d = ST_ERR;
`else
                  index_d = 7'd64;
                  state_d = ST_DONE;
`endif
               end
            end else begin
`ifdef HUFF_CTRL_ERR_DETECT_EN
               state_d = ST_ERR;
`else
               state_d = ST_DONE;
`endif
            end
         end

         ST_COEFF: begin
            coeff_en_b_s2 = 1'b0;
            if (bit_valid_s1) begin
               if (bit_cnt_q == 4'd1) begin
                  reset_sr_s2 = 1'b1;
                  bit_cnt_d   = 4'd0;
                  code_len_d  = 4'd1;
                  // a position past 63 has no zig-zag slot, so nothing is emitted
                  if (pos <= 7'd63) begin
                     coeff_valid_s2 = 1'b1;
                     index_d        = nxt_idx;
                     state_d        = (nxt_idx == 7'd64) ? ST_DONE : ST_CODE;
                  end else begin
`ifdef HUFF_CTRL_ERR_DETECT_EN
                     state_d = ST_ERR;
`else
                     index_d = 7'd64;
                     state_d = ST_DONE;
`endif
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q - 4'd1;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign table1_addr_s1 = code_len_q;
   assign run_s2         = run_q;
   assign size_s2        = size_q;
   assign index_s2       = pos[5:0];
   assign busy_s1        = (state_q == ST_CODE) || (state_q == ST_LOOKUP) ||
                           (state_q == ST_COEFF);
   assign block_done_s1  = (state_q == ST_DONE);
   assign err_s1         = (state_q == ST_ERR);

endmodule

// File: tb/tb_huff_ctrl.sv
// Directed bench for huff_ctrl. Inputs change 2 time units after the rising
// edge; outputs are sampled 1 unit after inputs settle, well away from the edge.

module tb_huff_ctrl;

   logic       phi1 = 1'b0;
   logic       reset_b;
   logic       start_s1;
   logic       bit_valid_s1;
   logic       match_s1;
   logic [7:0] table2_data_v1;
   logic [3:0] table1_addr_s1;
   logic       reset_sr_s2;
   logic       coeff_en_b_s2;
   logic       coeff_valid_s2;
   logic [3:0] run_s2;
   logic [3:0] size_s2;
   logic [5:0] index_s2;
   logic       busy_s1;
   logic       block_done_s1;
   logic       err_s1;

   int total = 0;
   int bad   = 0;

   huff_ctrl dut (
      .phi1           (phi1),
      .reset_b        (reset_b),
      .start_s1       (start_s1),
      .bit_valid_s1   (bit_valid_s1),
      .match_s1       (match_s1),
      .table2_data_v1 (table2_data_v1),
      .table1_addr_s1 (table1_addr_s1),
      .reset_sr_s2    (reset_sr_s2),
      .coeff_en_b_s2  (coeff_en_b_s2),
      .coeff_valid_s2 (coeff_valid_s2),
      .run_s2         (run_s2),
      .size_s2        (size_s2),
      .index_s2       (index_s2),
      .busy_s1        (busy_s1),
      .block_done_s1  (block_done_s1),
      .err_s1         (err_s1)
   );

   always #5 phi1 = ~phi1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge phi1);
      #2;
   endtask

   task automatic chk_rst_outputs(input string tag);
      chk({tag, "_addr"},  table1_addr_s1, 1);
      chk({tag, "_rsr"},   reset_sr_s2,    0);
      chk({tag, "_enb"},   coeff_en_b_s2,  1);
      chk({tag, "_cv"},    coeff_valid_s2, 0);
      chk({tag, "_run"},   run_s2,         0);
      chk({tag, "_size"},  size_s2,        0);
      chk({tag, "_index"}, index_s2,       0);
      chk({tag, "_busy"},  busy_s1,        0);
      chk({tag, "_done"},  block_done_s1,  0);
      chk({tag, "_err"},   err_s1,         0);
   endtask

   task automatic do_start();
      start_s1 = 1'b1;
      tick();
      start_s1 = 1'b0;
   endtask

   // len-1 bits without match, then a matching bit, then the LOOKUP cycle
   task automatic send_code(input int len, input logic [7:0] sym);
      for (int i = 1; i < len; i++) begin
         bit_valid_s1 = 1'b1; match_s1 = 1'b0; tick();
      end
      bit_valid_s1 = 1'b1; match_s1 = 1'b1; tick();
      bit_valid_s1 = 1'b0; match_s1 = 1'b0; table2_data_v1 = sym; tick();
      table2_data_v1 = 8'h00;
   endtask

   task automatic send_bits(input int n);
      for (int i = 0; i < n; i++) begin
         bit_valid_s1 = 1'b1; tick();
      end
      bit_valid_s1 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_b = 1'b0; start_s1 = 1'b0; bit_valid_s1 = 1'b0; match_s1 = 1'b0;
      table2_data_v1 = 8'h00;
      #23;
      chk_rst_outputs("por");
      tick();
      reset_b = 1'b1;
      tick();
      chk("idle_busy", busy_s1, 0);

      // basic coefficient: match at length 2, 0x03, three bits
      do_start();
      chk("b1_busy", busy_s1, 1);
      chk("b1_addr1", table1_addr_s1, 1);
      bit_valid_s1 = 1'b1; match_s1 = 1'b1; #1;
      chk("b1_len1_nomatch", reset_sr_s2, 0);
      tick();
      chk("b1_addr2", table1_addr_s1, 2);
      bit_valid_s1 = 1'b1; match_s1 = 1'b1; #1;
      chk("b1_match_rsr", reset_sr_s2, 1);
      chk("b1_match_enb", coeff_en_b_s2, 1);
      tick();
      bit_valid_s1 = 1'b0; match_s1 = 1'b0; table2_data_v1 = 8'h03; #1;
      chk("b1_lookup_rsr", reset_sr_s2, 0);
      chk("b1_lookup_busy", busy_s1, 1);
      tick();
      table2_data_v1 = 8'h00;
      chk("b1_coeff_size", size_s2, 3);
      chk("b1_coeff_enb", coeff_en_b_s2, 0);
      bit_valid_s1 = 1'b1; #1;
      chk("b1_bit1_cv", coeff_valid_s2, 0);
      tick();
      tick();
      #1;
      chk("b1_last_cv", coeff_valid_s2, 1);
      chk("b1_last_rsr", reset_sr_s2, 1);
      chk("b1_last_enb", coeff_en_b_s2, 0);
      chk("b1_last_run", run_s2, 0);
      chk("b1_last_size", size_s2, 3);
      chk("b1_last_index", index_s2, 0);
      tick();
      bit_valid_s1 = 1'b0; #1;
      chk("b1_after_cv", coeff_valid_s2, 0);
      chk("b1_after_rsr", reset_sr_s2, 0);
      chk("b1_after_addr", table1_addr_s1, 1);
      // start while busy: code length must survive
      send_bits(1);
      start_s1 = 1'b1; tick(); start_s1 = 1'b0;
      chk("b1_start_ignored", table1_addr_s1, 2);
      bit_valid_s1 = 1'b1; match_s1 = 1'b1; tick();
      bit_valid_s1 = 1'b0; match_s1 = 1'b0; table2_data_v1 = 8'h00; tick();
      chk("b1_eob_done", block_done_s1, 1);
      chk("b1_eob_busy", busy_s1, 0);
      tick();
      chk("b1_done_hold", block_done_s1, 1);

      // ZRL then run 2 size 1, then EOB
      do_start();
      chk("z_done_clr", block_done_s1, 0);
      send_code(2, 8'hF0);
      chk("z_code_addr", table1_addr_s1, 1);
      chk("z_code_busy", busy_s1, 1);
      send_code(3, 8'h21);
      bit_valid_s1 = 1'b1; #1;
      chk("z_cv", coeff_valid_s2, 1);
      chk("z_index", index_s2, 18);
      chk("z_run", run_s2, 2);
      chk("z_size", size_s2, 1);
      tick();
      bit_valid_s1 = 1'b0;
      send_code(2, 8'h00);
      chk("z_done", block_done_s1, 1);
      chk("z_err", err_s1, 0);

      // stalls in CODE and COEFF
      do_start();
      send_bits(1);
      for (int i = 0; i < 4; i++) begin
         bit_valid_s1 = 1'b0; match_s1 = 1'b1; #1;
         chk("s_code_rsr", reset_sr_s2, 0);
         tick();
         chk("s_code_addr", table1_addr_s1, 2);
      end
      bit_valid_s1 = 1'b1; match_s1 = 1'b1; tick();
      bit_valid_s1 = 1'b0; match_s1 = 1'b0; table2_data_v1 = 8'h02; tick();
      table2_data_v1 = 8'h00;
      send_bits(1);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("s_coeff_cv", coeff_valid_s2, 0);
         chk("s_coeff_enb", coeff_en_b_s2, 0);
         tick();
      end
      bit_valid_s1 = 1'b1; #1;
      chk("s_cv", coeff_valid_s2, 1);
      chk("s_index", index_s2, 0);
      chk("s_size", size_s2, 2);
      tick();
      bit_valid_s1 = 1'b0;
      send_code(2, 8'h00);
      chk("s_done", block_done_s1, 1);

      // asynchronous reset in the middle of a size-5 coefficient
      do_start();
      send_code(2, 8'h05);
      send_bits(2);
      #1;
      reset_b = 1'b0;
      #1;
      chk_rst_outputs("mid");
      bit_valid_s1 = 1'b1;
      tick();
      reset_b = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("mid_post_cv", coeff_valid_s2, 0);
         chk("mid_post_busy", busy_s1, 0);
         tick();
      end
      bit_valid_s1 = 1'b0;

      // no match through length 9
      do_start();
      send_bits(8);
      chk("l9_addr", table1_addr_s1, 9);
      bit_valid_s1 = 1'b1; match_s1 = 1'b0; #1;
`ifdef HUFF_CTRL_ERR_DETECT_EN
      chk("l9_rsr", reset_sr_s2, 0);
      tick();
      bit_valid_s1 = 1'b0;
      chk("l9_err", err_s1, 1);
      chk("l9_busy", busy_s1, 0);
      do_start();
      chk("l9_err_clr", err_s1, 0);
      send_code(2, 8'h00);
`else
      chk("l9_rsr", reset_sr_s2, 1);
      tick();
      bit_valid_s1 = 1'b0;
      chk("l9_lookup_busy", busy_s1, 1);
      chk("l9_lookup_addr", table1_addr_s1, 9);
      chk("l9_err", err_s1, 0);
      table2_data_v1 = 8'h00; tick();
`endif
      chk("l9_end_done", block_done_s1, 1);

      // illegal size-0 symbol
      do_start();
      send_code(2, 8'h30);
`ifdef HUFF_CTRL_ERR_DETECT_EN
      chk("ill_err", err_s1, 1);
      chk("ill_done", block_done_s1, 0);
`else
      chk("ill_err", err_s1, 0);
      chk("ill_done", block_done_s1, 1);
`endif

      // 64 coefficients of run 0 size 1 fill the block without EOB
      do_start();
      for (int k = 0; k < 64; k++) begin
         if (k == 10) begin
            start_s1 = 1'b1; tick(); start_s1 = 1'b0;
         end
         send_code(2, 8'h01);
         bit_valid_s1 = 1'b1; #1;
         chk("full_cv", coeff_valid_s2, 1);
         chk("full_index", index_s2, k);
         tick();
         bit_valid_s1 = 1'b0;
         if (k == 62) chk("full_busy63", busy_s1, 1);
      end
      chk("full_done", block_done_s1, 1);
      chk("full_busy", busy_s1, 0);
      chk("full_err", err_s1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
